sa_fetch_unit: RTL and testbench
================================

Name: sa_fetch_unit

Overview:
- CPU-side initiator for the set-associative instruction cache.
- Generates sequential fetch addresses from a PC and drives the cache request/address inputs.
- Waits out miss handling signalled by the cache busy flag, then captures the returned instruction word.
- Buffers fetched {pc, instruction} pairs in a small FIFO toward decode and supports PC redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 4, instruction FIFO entries (power of 2, ≥2).
- CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cpu_req_out  output  1  fetch request to cache.
- cpu_addr_out  output  32  fetch address to cache.
- i_cache_busy_in  input  1  cache servicing a miss; data not ready.
- cache_data_in  input  32  instruction word from cache.
- redirect_valid  input  1  one-cycle pulse: load new PC, flush.
- redirect_pc  input  32  redirect target (bits [1:0] ignored, forced 0).
- instr_valid_out  output  1  FIFO head valid.
- instr_out  output  32  FIFO head instruction.
- instr_pc_out  output  32  FIFO head PC.
- instr_ready_in  input  1  consumer pops head when valid & ready.
- fifo_count_out  output  CNT_W  current FIFO occupancy.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on reset_n. While reset_n is low:
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - FIFO empty, count=0.
  - Outputs: cpu_req_out=0, cpu_addr_out=RESET_PC, instr_valid_out=0, instr_out=0, instr_pc_out=0, fifo_count_out=0.
  - Reset mid-access abandons the access with no capture.
- At most one access outstanding. cpu_addr_out is always the req_addr register and holds stable while cpu_req_out=1.
- IDLE (cpu_req_out=0):
  - If count<DEPTH, go to ISSUE with req_addr<=pc.
  - Otherwise stay in IDLE.
- ISSUE (cpu_req_out=1): always go to WAIT next cycle. The cache samples the request in this cycle.
- WAIT (cpu_req_out=1):
  - i_cache_busy_in=1: stay in WAIT; req and addr held.
  - i_cache_busy_in=0: push {req_addr, cache_data_in} into the FIFO and set pc<=req_addr+4 (mod 2^32, wraps FFFF_FFFC→0).
  - After the push, go to ISSUE with req_addr<=pc+4 if post-push count<DEPTH; otherwise go to IDLE.
  - Hit latency is 2 cycles/instruction (ISSUE+WAIT). A miss adds one cycle per busy cycle.
- DROP (cpu_req_out=1, old req_addr held):
  - Stay in DROP while busy=1.
  - On the first cycle busy=0, discard cache_data_in (no push) and go to ISSUE if count<DEPTH, else IDLE. req_addr<=pc on entering ISSUE.
- Redirect: redirect_valid has the highest priority in every state.
  - pc<=redirect_pc&~3; FIFO flushed (count<=0, head/tail<=0). A pop in the same cycle is ignored.
  - IDLE: go to ISSUE with req_addr<=new pc.
  - ISSUE: go to DROP (the cache already accepted the old address).
  - WAIT with busy=1: go to DROP.
  - WAIT with busy=0: data discarded, go to ISSUE with req_addr<=new pc.
  - DROP: update pc, stay in DROP.
- FIFO:
  - Circular buffer, registered storage.
  - instr_valid_out=(count!=0); head fields are driven from storage.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap mod DEPTH.
  - Push never occurs when full; this is guaranteed by the IDLE/ISSUE space check.
  - Pop when empty is ignored.
- FIFO outputs read 0 when empty.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 mid-WAIT, then release.
  - Required: all outputs at reset values. First ISSUE after reset drives cpu_addr_out=RESET_PC.
- Hit stream:
  - Stimulus: busy=0 always, cache_data_in=~addr, ready=1.
  - Required: instructions for PCs 0,4,8,C appear every 2 cycles with instr_out=~pc.
- Miss:
  - Stimulus: busy=1 for 10 cycles at PC 8.
  - Required: cpu_addr_out held at 8 for all 10 cycles. Capture occurs on the 11th WAIT cycle. Next address is C.
- Backpressure:
  - Stimulus: ready=0, DEPTH=4.
  - Required: exactly 4 entries, fifo_count_out=4, state IDLE with cpu_req_out=0.
  - Then one pop: a new ISSUE follows the next cycle.
- Redirect during miss:
  - Stimulus: redirect_pc=0x100 while in WAIT with busy=1.
  - Required: FIFO count→0. Old address is held until busy falls and its data is dropped. Next ISSUE uses 0x100.
  - Also: redirect_pc=0x103 → fetch from 0x100.
- PC wrap:
  - Stimulus: redirect to FFFF_FFFC.
  - Required: captured instr_pc_out=FFFF_FFFC, next fetch address 0000_0000.

Source files
------------

// File: rtl/sa_fetch_unit.sv
// Sequential instruction fetch initiator for the set-associative I-cache.
// One access in flight at a time; fetched {pc, instr} pairs queue toward decode.
module sa_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             cpu_req_out,
  output logic [31:0]      cpu_addr_out,
  input  logic             i_cache_busy_in,
  input  logic [31:0]      cache_data_in,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             instr_valid_out,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc_out,
  input  logic             instr_ready_in,
  output logic [CNT_W-1:0] fifo_count_out
);

  // state | meaning
  // IDLE  | no access; waiting for FIFO space
  // ISSUE | request presented, cache samples req_addr this cycle
  // WAIT  | access outstanding; capture on first cycle busy is low
  // DROP  | access outstanding but redirected; its data is discarded
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];

  logic [31:0] redirect_al;
  logic [31:0] next_seq;
  logic        push;
  logic        pop;
  logic        has_space;

  assign redirect_al = redirect_pc & ~32'd3;
  assign next_seq    = req_addr_q + 32'd4;
  assign has_space   = count_q < DEPTH_C;

  // A redirect flushes the queue, so neither a capture nor a pop may land that cycle.
  assign push = (state_q == S_WAIT) && !i_cache_busy_in && !redirect_valid;
  assign pop  = instr_valid_out && instr_ready_in && !redirect_valid;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop)
      count_d = count_q - CNT_W'(1);
    if (redirect_valid)
      count_d = '0;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (redirect_valid) begin
      pc_d = redirect_al;
      case (state_q)
        S_IDLE: begin
          state_d    = S_ISSUE;
          req_addr_d = redirect_al;
        end
        S_ISSUE: state_d = S_DROP;
        S_WAIT: begin
          if (i_cache_busy_in) begin
            state_d = S_DROP;
          end else begin
            state_d    = S_ISSUE;
            req_addr_d = redirect_al;
          end
        end
        default: state_d = S_DROP;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (has_space) begin
            state_d    = S_ISSUE;
            req_addr_d = pc_q;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (!i_cache_busy_in) begin
            pc_d = next_seq;
            if (count_d < DEPTH_C) begin
              state_d    = S_ISSUE;
              req_addr_d = next_seq;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          if (!i_cache_busy_in) begin
            if (has_space) begin
              state_d    = S_ISSUE;
              req_addr_d = pc_q;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PTR_W'(1);
        if (pop)  head_q <= head_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push) begin
      mem_pc[tail_q]    <= req_addr_q;
      mem_instr[tail_q] <= cache_data_in;
    end
  end

  assign cpu_req_out     = (state_q != S_IDLE);
  assign cpu_addr_out    = req_addr_q;
  assign instr_valid_out = (count_q != '0);
  assign instr_out       = instr_valid_out ? mem_instr[head_q] : 32'd0;
  assign instr_pc_out    = instr_valid_out ? mem_pc[head_q]    : 32'd0;
  assign fifo_count_out  = count_q;

endmodule

// File: tb/tb_sa_fetch_unit.sv
// Self-checking bench for sa_fetch_unit: directed scenarios plus a randomized
// run scored against a stream-level model of the expected instruction sequence.
module tb_sa_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = 3;

  logic             clk;
  logic             reset_n;
  logic             cpu_req_out;
  logic [31:0]      cpu_addr_out;
  logic             i_cache_busy_in;
  logic [31:0]      cache_data_in;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             instr_valid_out;
  logic [31:0]      instr_out;
  logic [31:0]      instr_pc_out;
  logic             instr_ready_in;
  logic [CNT_W-1:0] fifo_count_out;

  int n_checks = 0;
  int n_fail   = 0;

  sa_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_req_out     (cpu_req_out),
    .cpu_addr_out    (cpu_addr_out),
    .i_cache_busy_in (i_cache_busy_in),
    .cache_data_in   (cache_data_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid_out (instr_valid_out),
    .instr_out       (instr_out),
    .instr_pc_out    (instr_pc_out),
    .instr_ready_in  (instr_ready_in),
    .fifo_count_out  (fifo_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cache_data_in = ~cpu_addr_out;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    instr_ready_in  = 1'b0;
    i_cache_busy_in = 1'b0;
    cache_data_in   = 32'd0;
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    cache_data_in = ~cpu_addr_out;
  endtask

  task automatic test_reset();
    logic [31:0] exp_addr;
    exp_addr = RESET_PC;
    do_reset();
    n_checks++;
    if ({cpu_req_out, instr_valid_out, fifo_count_out} !== {1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: req/valid/count got %b/%b/%0d want 0/0/0", cpu_req_out, instr_valid_out, fifo_count_out);
    end
    n_checks++;
    if ({cpu_addr_out, instr_out, instr_pc_out} !== {exp_addr, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_data: addr/instr/pc got %h/%h/%h want %h/0/0", cpu_addr_out, instr_out, instr_pc_out, exp_addr);
    end
    step();
    i_cache_busy_in = 1'b1;
    step();
    step();
    // Abandon the outstanding access asynchronously, between edges.
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_req_out, instr_valid_out, fifo_count_out, cpu_addr_out} !== {1'b0, 1'b0, 3'd0, exp_addr}) begin
      n_fail++;
      $display("FAIL reset_mid_wait: req/valid/count/addr got %b/%b/%0d/%h", cpu_req_out, instr_valid_out, fifo_count_out, cpu_addr_out);
    end
    @(posedge clk);
    #1;
    reset_n         = 1'b1;
    i_cache_busy_in = 1'b0;
    step();
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, exp_addr}) begin
      n_fail++;
      $display("FAIL reset_first_issue: req/addr got %b/%h want 1/%h", cpu_req_out, cpu_addr_out, exp_addr);
    end
  endtask

  task automatic test_hit_stream();
    logic [31:0] exp_pc;
    do_reset();
    instr_ready_in = 1'b1;
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      exp_pc = RESET_PC + 32'(4 * k);
      n_checks++;
      if ({instr_valid_out, instr_pc_out, instr_out} !== {1'b1, exp_pc, ~exp_pc}) begin
        n_fail++;
        $display("FAIL hit_entry%0d: valid/pc/instr got %b/%h/%h want 1/%h/%h", k, instr_valid_out, instr_pc_out, instr_out, exp_pc, ~exp_pc);
      end
      step();
      n_checks++;
      if (instr_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_gap%0d: valid got %b want 0", k, instr_valid_out);
      end
      step();
    end
  endtask

  task automatic test_miss();
    do_reset();
    instr_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL miss_issue8: req/addr got %b/%h want 1/00000008", cpu_req_out, cpu_addr_out);
    end
    i_cache_busy_in = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      cache_data_in = $urandom;
      n_checks++;
      if ({cpu_req_out, cpu_addr_out, fifo_count_out} !== {1'b1, 32'h8, 3'd0}) begin
        n_fail++;
        $display("FAIL miss_hold%0d: req/addr/count got %b/%h/%0d want 1/00000008/0", i, cpu_req_out, cpu_addr_out, fifo_count_out);
      end
      step();
    end
    i_cache_busy_in = 1'b0;
    step();
    n_checks++;
    if ({instr_valid_out, instr_pc_out, instr_out} !== {1'b1, 32'h8, ~32'h8}) begin
      n_fail++;
      $display("FAIL miss_capture: valid/pc/instr got %b/%h/%h want 1/00000008/%h", instr_valid_out, instr_pc_out, instr_out, ~32'h8);
    end
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL miss_next: req/addr got %b/%h want 1/0000000c", cpu_req_out, cpu_addr_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if ({cpu_req_out, fifo_count_out, instr_valid_out} !== {1'b0, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_full: req/count/valid got %b/%0d/%b want 0/4/1", cpu_req_out, fifo_count_out, instr_valid_out);
    end
    n_checks++;
    if ({instr_pc_out, instr_out} !== {32'h0, ~32'h0}) begin
      n_fail++;
      $display("FAIL bp_head: pc/instr got %h/%h want 00000000/ffffffff", instr_pc_out, instr_out);
    end
    instr_ready_in = 1'b1;
    step();
    instr_ready_in = 1'b0;
    n_checks++;
    if ({cpu_req_out, fifo_count_out, instr_pc_out} !== {1'b0, 3'd3, 32'h4}) begin
      n_fail++;
      $display("FAIL bp_pop: req/count/head got %b/%0d/%h want 0/3/00000004", cpu_req_out, fifo_count_out, instr_pc_out);
    end
    step();
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL bp_reissue: req/addr got %b/%h want 1/00000010", cpu_req_out, cpu_addr_out);
    end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    step(); step(); step();
    i_cache_busy_in = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({cpu_req_out, cpu_addr_out, fifo_count_out} !== {1'b1, 32'h4, 3'd0}) begin
        n_fail++;
        $display("FAIL redir_hold%0d: req/addr/count got %b/%h/%0d want 1/00000004/0", i, cpu_req_out, cpu_addr_out, fifo_count_out);
      end
      if (i < 3) step();
    end
    i_cache_busy_in = 1'b0;
    step();
    n_checks++;
    if ({cpu_req_out, cpu_addr_out, fifo_count_out} !== {1'b1, 32'h100, 3'd0}) begin
      n_fail++;
      $display("FAIL redir_issue: req/addr/count got %b/%h/%0d want 1/00000100/0", cpu_req_out, cpu_addr_out, fifo_count_out);
    end
    step(); step();
    n_checks++;
    if ({instr_valid_out, instr_pc_out, instr_out} !== {1'b1, 32'h100, ~32'h100}) begin
      n_fail++;
      $display("FAIL redir_capture: valid/pc/instr got %b/%h/%h", instr_valid_out, instr_pc_out, instr_out);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if ({fifo_count_out, cpu_addr_out} !== {3'd0, 32'h104}) begin
      n_fail++;
      $display("FAIL redir_issue_drop: count/addr got %0d/%h want 0/00000104", fifo_count_out, cpu_addr_out);
    end
    step();
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL redir_align: req/addr got %b/%h want 1/00000100", cpu_req_out, cpu_addr_out);
    end
    step(); step();
    n_checks++;
    if ({instr_valid_out, instr_pc_out, fifo_count_out} !== {1'b1, 32'h100, 3'd1}) begin
      n_fail++;
      $display("FAIL redir_align_capture: valid/pc/count got %b/%h/%0d", instr_valid_out, instr_pc_out, fifo_count_out);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_issue: req/addr got %b/%h want 1/fffffffc", cpu_req_out, cpu_addr_out);
    end
    step(); step();
    n_checks++;
    if ({instr_valid_out, instr_pc_out, instr_out} !== {1'b1, 32'hFFFF_FFFC, 32'h3}) begin
      n_fail++;
      $display("FAIL wrap_capture: valid/pc/instr got %b/%h/%h want 1/fffffffc/00000003", instr_valid_out, instr_pc_out, instr_out);
    end
    n_checks++;
    if ({cpu_req_out, cpu_addr_out} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_next: req/addr got %b/%h want 1/00000000", cpu_req_out, cpu_addr_out);
    end
  endtask

  // Model: decode must see a gap-free stream of consecutive word addresses,
  // each carrying ~pc, restarting at the aligned target after every redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_held;
    int          pops;
    exp_pc    = RESET_PC;
    prev_held = 1'b0;
    prev_addr = 32'd0;
    pops      = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (prev_held) begin
        n_checks++;
        if ({cpu_req_out, cpu_addr_out} !== {1'b1, prev_addr}) begin
          n_fail++;
          $display("FAIL rand_hold c%0d: req/addr got %b/%h want 1/%h", c, cpu_req_out, cpu_addr_out, prev_addr);
        end
      end
      n_checks++;
      if (fifo_count_out > 3'(DEPTH) || instr_valid_out !== (fifo_count_out != 3'd0)) begin
        n_fail++;
        $display("FAIL rand_count c%0d: count/valid got %0d/%b", c, fifo_count_out, instr_valid_out);
      end
      i_cache_busy_in = ($urandom_range(0, 99) < 30);
      instr_ready_in  = ($urandom_range(0, 99) < 60);
      redirect_valid  = ($urandom_range(0, 99) < 3);
      redirect_pc     = $urandom;
      cache_data_in   = i_cache_busy_in ? $urandom : ~cpu_addr_out;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'd3;
      end else if (instr_valid_out && instr_ready_in) begin
        n_checks++;
        if ({instr_pc_out, instr_out} !== {exp_pc, ~exp_pc}) begin
          n_fail++;
          $display("FAIL rand_pop c%0d: pc/instr got %h/%h want %h/%h", c, instr_pc_out, instr_out, exp_pc, ~exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_held = cpu_req_out && i_cache_busy_in;
      prev_addr = cpu_addr_out;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (pops < 100) begin
      n_fail++;
      $display("FAIL rand_progress: pops got %0d want at least 100", pops);
    end
    instr_ready_in  = 1'b0;
    redirect_valid  = 1'b0;
    i_cache_busy_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_miss();
    test_backpressure();
    test_redirect_miss();
    test_pc_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
